// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned BIN_W_DEF    = 16;
    localparam int unsigned DIGITS_DEF   = 5;
    localparam int unsigned DIGIT_THRESH = 5;
    localparam int unsigned DIGIT_CORR   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5..9 before the shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Codes 10..15 cannot occur in a valid working register, so they map to 0.
    always_comb begin
        dout = din;
        if (din > 4'd9) begin
            dout = 4'd0;
        end else if (din >= 4'(DIGIT_THRESH)) begin
            dout = din + 4'(DIGIT_CORR);
        end
    end

endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
// Define BCD_SIGNED_EN to treat bin as two's complement and report the sign on neg.
module bcd_convert_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = BIN_W_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned REG_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    state_t             state;
    logic [REG_W-1:0]   work;
    logic [REG_W-1:0]   adj;
    logic [REG_W-1:0]   shifted;
    logic [CNT_W-1:0]   cnt;
    logic [BIN_W-1:0]   operand;
    logic               last;

`ifdef BCD_SIGNED_EN
    logic sign_in;
    logic sign_lat;

    // Magnitude of the two's-complement operand; the most negative value maps onto itself unsigned.
    always_comb begin
        sign_in = bin[BIN_W-1];
        operand = sign_in ? (~bin + BIN_W'(1)) : bin;
    end
`else
    always_comb begin
        operand = bin;
    end
`endif

    // One correction cell per BCD digit sitting above the binary field.
    genvar g;
    generate
        for (g = 0; g < int'(DIGITS); g++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (work[BIN_W + 4*g +: 4]),
                .dout (adj[BIN_W + 4*g +: 4])
            );
        end
    endgenerate

    always_comb begin
        adj[BIN_W-1:0] = work[BIN_W-1:0];
    end

    always_comb begin
        shifted = adj << 1;
        last    = (cnt == CNT_W'(BIN_W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
            work  <= '0;
`ifdef BCD_SIGNED_EN
            sign_lat <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        work  <= {BCD_W'(0), operand};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
`ifdef BCD_SIGNED_EN
                        sign_lat <= sign_in;
`endif
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    if (last) begin
                        bcd   <= shifted[REG_W-1 -: BCD_W];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
`ifdef BCD_SIGNED_EN
                        neg   <= sign_lat;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Directed self-checking bench for bcd_convert_seq (unsigned build unless BCD_SIGNED_EN is defined).
module tb_bcd_convert_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic        neg;

    int tests_run;
    int tests_failed;

    bcd_convert_seq #(.BIN_W(16), .DIGITS(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .neg   (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until done is seen (bounded); n is cycles waited, busy_gap flags a cycle with neither busy nor done.
    task automatic wait_done(output int n, output logic busy_gap);
        n = 0;
        busy_gap = 1'b0;
        while (n < 40) begin
            step();
            n++;
            if (done) break;
            if (!busy) busy_gap = 1'b1;
        end
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (done) cnt++;
        end
    endtask

    task automatic conv(input string tag, input logic [15:0] v,
                        input logic [19:0] exp_bcd, input logic exp_neg);
        int   n;
        logic gap;
        start = 1'b1;
        bin   = v;
        step();
        start = 1'b0;
        bin   = 16'($urandom);
        wait_done(n, gap);
        check({tag, " latency"}, 32'(n), 32'd16);
        check({tag, " bcd"}, 32'(bcd), 32'(exp_bcd));
        check({tag, " neg"}, 32'(neg), 32'(exp_neg));
        check({tag, " busy_during_done"}, 32'(busy), 32'd0);
        check({tag, " busy_gap"}, 32'(gap), 32'd0);
        step();
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int   n;
        int   cnt;
        logic gap;
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b1;
        start = 1'b0;
        bin   = 16'd0;
        step();
        step();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset bcd", 32'(bcd), 32'd0);
        check("reset neg", 32'(neg), 32'd0);
        rst = 1'b0;
        step();

        conv("zero", 16'd0, 20'h00000, 1'b0);
`ifdef BCD_SIGNED_EN
        conv("min_neg", 16'h8000, 20'h32768, 1'b1);
        conv("minus_one", 16'hFFFF, 20'h00001, 1'b1);
        conv("max_pos", 16'h7FFF, 20'h32767, 1'b0);
`else
        conv("max", 16'd65535, 20'h65535, 1'b0);
`endif
        conv("v1234", 16'd1234, 20'h01234, 1'b0);
        conv("v9", 16'd9, 20'h00009, 1'b0);

        // start during SHIFT is ignored
        start = 1'b1;
        bin   = 16'd100;
        step();
        start = 1'b0;
        repeat (4) step();
        start = 1'b1;
        bin   = 16'd7;
        step();
        start = 1'b0;
        wait_done(n, gap);
        check("ignore latency", 32'(n + 5), 32'd16);
        check("ignore bcd", 32'(bcd), 32'h00100);
        count_dones(20, cnt);
        check("ignore single_done", 32'(cnt), 32'd0);

        // reset mid-conversion, with start asserted alongside it
        start = 1'b1;
        bin   = 16'd4321;
        step();
        start = 1'b0;
        repeat (8) step();
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort bcd", 32'(bcd), 32'd0);
        check("abort done", 32'(done), 32'd0);
        count_dones(20, cnt);
        check("abort no_done", 32'(cnt), 32'd0);
        check("abort idle", 32'(busy), 32'd0);
        conv("after_abort", 16'd42, 20'h00042, 1'b0);

        // start held: back-to-back conversions, one result per 17 cycles
        start = 1'b1;
        bin   = 16'd1;
        step();
        bin = 16'd2;
        wait_done(n, gap);
        check("b2b first latency", 32'(n), 32'd16);
        check("b2b first bcd", 32'(bcd), 32'h00001);
        wait_done(n, gap);
        start = 1'b0;
        check("b2b period", 32'(n), 32'd17);
        check("b2b second bcd", 32'(bcd), 32'h00002);
        step();
        check("b2b stop busy", 32'(busy), 32'd0);
        check("b2b stop done", 32'(done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bcd_convert_seq.md
# bcd_convert_seq

Sequential binary-to-BCD converter for the 16-bit controller's display/readout path. It uses shift-and-add-3, the "double dabble" method. Each clock it applies an add-3 correction to every BCD digit of at least 5, then shifts one input bit in. A 16-bit value converts in 16 iterations, so one shared set of correction cells replaces a wide combinational array. A start/busy/done handshake lets the front-panel sequencer request conversions and collect results.

## Interface
- `BIN_W`, default 16: binary input width.
- `DIGITS`, default 5: BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W − 1.
- `clk` input, 1 bit: sole clock, rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `start` input, 1 bit: conversion request, sampled on `clk`.
- `bin` input, `BIN_W` bits: operand, captured on the accepting edge only.
- `busy` output, 1 bit: high while iterating.
- `done` output, 1 bit: one-cycle completion pulse.
- `bcd` output, 4·`DIGITS` bits: result. Digit 0 is at [3:0]. The value is held until the next completion.
- `neg` output, 1 bit: sign of the last result. Constant 0 unless `BCD_SIGNED_EN` is defined.

## Operation
- States:
  - IDLE: waiting.
  - SHIFT: iterating.
  - DONE: result presented, lasts one cycle.
- IDLE or DONE with `start`=1:
  - Load the working register {4·`DIGITS` zeros, `bin`}.
  - Clear the iteration counter to 0.
  - Go to SHIFT.
- IDLE or DONE with `start`=0: go to IDLE.
- SHIFT, each cycle:
  - For every digit of the working register, replace the digit with digit+3 if it is ≥ 5, otherwise leave it unchanged. All digits are corrected in parallel.
  - Shift the whole register left by 1.
  - Increment the counter.
- SHIFT with counter = `BIN_W`−1: this is the last iteration.
  - Load `bcd` with the upper 4·`DIGITS` bits of the shifted result.
  - Go to DONE.
- Counter width is $clog2(`BIN_W`). It never wraps within a conversion.
- `start` in SHIFT is ignored. It is not queued.
- No digit ever exceeds 9 after correction. The shift-out of the MSB is discarded.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `bcd`=0, `neg`=0, counter 0, working register 0.
- Let E0 be the edge that accepts `start`. `busy` is high from after E0 through E16.
- At E16, `bcd` updates and `done` rises. `done` stays high for exactly one cycle. Latency is `BIN_W` cycles from acceptance to `done`.
- `busy`=0 during the DONE cycle. A `start` in that cycle is accepted, which gives back-to-back throughput of one result per `BIN_W`+1 cycles.
- `rst` during SHIFT:
  - The conversion is aborted and no `done` is issued.
  - `bcd` is cleared to 0.
  - The next cycle is IDLE.
- `rst` and `start` together: reset wins, and `start` is dropped.
- `bin` is don't-care except on the accepting edge.

## Configuration
- `BCD_SIGNED_EN` defined:
  - `bin` is treated as two's complement.
  - On acceptance, load the magnitude (−`bin` if `bin`[MSB]=1) and latch the sign internally.
  - `neg` updates together with `bcd` at completion.
  - −32768 converts to magnitude 32768.
- `BCD_SIGNED_EN` undefined:
  - `bin` is unsigned.
  - `neg` is tied to 0.
  - No negation logic is built.

## Structure
- Shared package `bcd_pkg`:
  - State encoding constants IDLE/SHIFT/DONE.
  - Default `BIN_W`/`DIGITS`.
  - The digit-threshold constant 5 and the correction constant 3.
- One sub-module, `bcd_digit_adj`: a combinational 4-bit cell that outputs in+3 for inputs 5–9 and in otherwise. Inputs 10–15 are unreachable and map to 0.
- `bcd_digit_adj` is instantiated `DIGITS` times in a generate loop over the working register.

## Test plan
- After reset: `bin`=0, pulse `start` → `busy` high 16 cycles, then `done` pulses once with `bcd`=0x00000.
- `bin`=65535 → `bcd`=0x65535. `bin`=1234 → `bcd`=0x01234. `bin`=9 → `bcd`=0x00009. Each `done` arrives exactly 16 cycles after acceptance.
- `start` with `bin`=100 is accepted; at cycle 5 assert `start` again with `bin`=7 → ignored. Result is 0x00100 with a single `done`.
- Start with `bin`=4321; assert `rst` at cycle 8 → no `done`, `bcd`=0, `busy`=0. A subsequent start with `bin`=42 yields 0x00042.
- `start` held continuously, `bin`=1 then 2 on successive acceptances → `done` every 17 cycles with results 0x00001, then 0x00002.
- `BCD_SIGNED_EN` defined: `bin`=0x8000 → `bcd`=0x32768, `neg`=1. `bin`=0xFFFF → `bcd`=0x00001, `neg`=1. `bin`=0x7FFF → `bcd`=0x32767, `neg`=0.
